// File: rtl/pilha_dados_if.sv
// Command/status bundle between the control unit and the pilha_dados data stack.
// pilha_wren is the only valid strobe; there is no ready, so every strobed command is taken on that edge.
interface pilha_dados_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) ();
  localparam int CW = $clog2(DEPTH + 1);

  logic             pilha_wren;
  logic             controle_pilha;
  logic             ula_wb;
  logic [WIDTH-1:0] data_pilha;
  logic [WIDTH-1:0] topo;
  logic [WIDTH-1:0] segundo;
  logic [CW-1:0]    contagem;
  logic             vazio;
  logic             cheio;
  logic             erro;

  modport master (
    output pilha_wren, controle_pilha, ula_wb, data_pilha,
    input  topo, segundo, contagem, vazio, cheio, erro
  );

  modport slave (
    input  pilha_wren, controle_pilha, ula_wb, data_pilha,
    output topo, segundo, contagem, vazio, cheio, erro
  );
endinterface

// File: rtl/pilha_dados.sv
// Data stack: top two entries in registers, deeper entries in a circular array of DEPTH-2 words.
// Define PILHA_GUARD_EN to reject illegal commands and flag erro; otherwise illegal commands saturate.
module pilha_dados #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic          clock,
  input  logic          reset,
  pilha_dados_if.slave  bus
);
  localparam int AD = DEPTH - 2;
  localparam int PW = (AD > 1) ? $clog2(AD) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = CW + 1;

  logic [WIDTH-1:0] topo_q, topo_d;
  logic [WIDTH-1:0] seg_q, seg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    base_q, base_d;
  logic             erro_q, erro_d;

  logic [WIDTH-1:0] mem [AD];
  logic             mem_we;
  logic [PW-1:0]    wr_idx, rd_idx;
  logic [SW-1:0]    wr_sum, rd_sum;
  logic [WIDTH-1:0] newest;
  logic             is_push, is_pop, is_wb;
  logic             vazio, cheio;

  assign vazio   = (cnt_q == '0);
  assign cheio   = (cnt_q == CW'(DEPTH));
  assign is_wb   = bus.pilha_wren & bus.ula_wb;
  assign is_push = bus.pilha_wren & ~bus.ula_wb & bus.controle_pilha;
  assign is_pop  = bus.pilha_wren & ~bus.ula_wb & ~bus.controle_pilha;

  // Array slot for the word leaving segundo is base+cnt-2; the newest array word sits at base+cnt-3.
  // On a full push this wraps onto base itself, which is exactly the oldest word being overwritten.
  assign wr_sum = SW'(base_q) + SW'(cnt_q) - SW'(2);
  assign rd_sum = SW'(base_q) + SW'(cnt_q) - SW'(3);
  assign wr_idx = (wr_sum >= SW'(AD)) ? PW'(wr_sum - SW'(AD)) : PW'(wr_sum);
  assign rd_idx = (rd_sum >= SW'(AD)) ? PW'(rd_sum - SW'(AD)) : PW'(rd_sum);
  assign newest = (cnt_q >= CW'(3)) ? mem[rd_idx] : '0;

`ifdef PILHA_GUARD_EN
  logic illegal;
  assign illegal = (is_push & cheio) | (is_pop & vazio) | (is_wb & (cnt_q < CW'(2)));
`endif

  always_comb begin
    topo_d = topo_q;
    seg_d  = seg_q;
    cnt_d  = cnt_q;
    base_d = base_q;
    erro_d = erro_q;
    mem_we = 1'b0;
`ifdef PILHA_GUARD_EN
    if (illegal) begin
      erro_d = 1'b1;
    end else if (is_wb) begin
      topo_d = bus.data_pilha;
      seg_d  = newest;
      cnt_d  = cnt_q - CW'(1);
    end else if (is_push) begin
      mem_we = (cnt_q >= CW'(2));
      seg_d  = topo_q;
      topo_d = bus.data_pilha;
      cnt_d  = cnt_q + CW'(1);
    end else if (is_pop) begin
      topo_d = seg_q;
      seg_d  = newest;
      cnt_d  = cnt_q - CW'(1);
    end
`else
    if (is_wb) begin
      topo_d = bus.data_pilha;
      if (cnt_q >= CW'(2)) begin
        seg_d = newest;
        cnt_d = cnt_q - CW'(1);
      end else begin
        cnt_d = CW'(1);
      end
    end else if (is_push) begin
      mem_we = (cnt_q >= CW'(2));
      seg_d  = topo_q;
      topo_d = bus.data_pilha;
      // Full: drop the oldest word by advancing base; the count saturates at DEPTH.
      if (cheio) begin
        base_d = (base_q == PW'(AD - 1)) ? '0 : base_q + PW'(1);
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else if (is_pop && !vazio) begin
      topo_d = seg_q;
      seg_d  = newest;
      cnt_d  = cnt_q - CW'(1);
    end
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      topo_q <= '0;
      seg_q  <= '0;
      cnt_q  <= '0;
      base_q <= '0;
      erro_q <= 1'b0;
    end else begin
      topo_q <= topo_d;
      seg_q  <= seg_d;
      cnt_q  <= cnt_d;
      base_q <= base_d;
      erro_q <= erro_d;
    end
  end

  // Array words are only read while they are live, so they need no reset.
  always_ff @(posedge clock) begin
    if (mem_we) mem[wr_idx] <= seg_q;
  end

  assign bus.topo     = topo_q;
  assign bus.segundo  = seg_q;
  assign bus.contagem = cnt_q;
  assign bus.vazio    = vazio;
  assign bus.cheio    = cheio;
  assign bus.erro     = erro_q;
endmodule

// File: tb/tb_pilha_dados.sv
// Bench for pilha_dados: a DEPTH=16 and a DEPTH=4 instance driven with identical commands
// and compared against a plain array model of a bounded stack.
module tb_pilha_dados;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  pilha_dados_if #(.WIDTH(16), .DEPTH(16)) b16 ();
  pilha_dados_if #(.WIDTH(16), .DEPTH(4))  b4 ();

  pilha_dados #(.WIDTH(16), .DEPTH(16)) u16 (.clock(clock), .reset(reset), .bus(b16.slave));
  pilha_dados #(.WIDTH(16), .DEPTH(4))  u4  (.clock(clock), .reset(reset), .bus(b4.slave));

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: ms[k][0] is the oldest entry, ms[k][mn[k]-1] is the top.
  int          mdepth[2] = '{16, 4};
  logic [15:0] ms[2][16];
  int          mn[2];
  bit          merr[2];
  logic [15:0] exp_q[$];

  typedef struct {
    logic        wren;
    logic        ctl;
    logic        wb;
    logic [15:0] d;
    logic [15:0] et;
    logic [15:0] es;
    int          ec;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mn[k]   = 0;
      merr[k] = 1'b0;
    end
  endtask

  task automatic model_step(input int k, input logic w, input logic c, input logic b,
                            input logic [15:0] d);
    if (!w) return;
    if (b) begin
      if (mn[k] >= 2) begin
        mn[k] -= 2;
        ms[k][mn[k]] = d;
        mn[k]++;
      end else begin
`ifdef PILHA_GUARD_EN
        merr[k] = 1'b1;
`else
        ms[k][0] = d;
        mn[k]    = 1;
`endif
      end
    end else if (c) begin
      if (mn[k] < mdepth[k]) begin
        ms[k][mn[k]] = d;
        mn[k]++;
      end else begin
`ifdef PILHA_GUARD_EN
        merr[k] = 1'b1;
`else
        for (int i = 0; i < mdepth[k] - 1; i++) ms[k][i] = ms[k][i + 1];
        ms[k][mdepth[k] - 1] = d;
`endif
      end
    end else begin
      if (mn[k] > 0) mn[k]--;
      else begin
`ifdef PILHA_GUARD_EN
        merr[k] = 1'b1;
`endif
      end
    end
  endtask

  task automatic check_dut(input int k, input string tag);
    logic [31:0] t, s, c, v, f, e;
    string p;
    if (k == 0) begin
      t = 32'(b16.topo); s = 32'(b16.segundo); c = 32'(b16.contagem);
      v = 32'(b16.vazio); f = 32'(b16.cheio); e = 32'(b16.erro);
    end else begin
      t = 32'(b4.topo); s = 32'(b4.segundo); c = 32'(b4.contagem);
      v = 32'(b4.vazio); f = 32'(b4.cheio); e = 32'(b4.erro);
    end
    p = $sformatf("%s/d%0d", tag, mdepth[k]);
    chk({p, "/topo"},     t, (mn[k] >= 1) ? 32'(ms[k][mn[k] - 1]) : 32'd0);
    chk({p, "/segundo"},  s, (mn[k] >= 2) ? 32'(ms[k][mn[k] - 2]) : 32'd0);
    chk({p, "/contagem"}, c, 32'(mn[k]));
    chk({p, "/vazio"},    v, 32'(mn[k] == 0));
    chk({p, "/cheio"},    f, 32'(mn[k] == mdepth[k]));
    chk({p, "/erro"},     e, 32'(merr[k]));
  endtask

  // Drive one command into both instances for one edge, then compare at the falling edge.
  task automatic step(input logic w, input logic c, input logic b, input logic [15:0] d,
                      input string tag);
    b16.pilha_wren = w; b16.controle_pilha = c; b16.ula_wb = b; b16.data_pilha = d;
    b4.pilha_wren  = w; b4.controle_pilha  = c; b4.ula_wb  = b; b4.data_pilha  = d;
    @(posedge clock);
    model_step(0, w, c, b, d);
    model_step(1, w, c, b, d);
    @(negedge clock);
    check_dut(0, tag);
    check_dut(1, tag);
  endtask

  initial begin
    logic [15:0] e;
    int r;

    b16.pilha_wren = 1'b0; b16.controle_pilha = 1'b0; b16.ula_wb = 1'b0; b16.data_pilha = '0;
    b4.pilha_wren  = 1'b0; b4.controle_pilha  = 1'b0; b4.ula_wb  = 1'b0; b4.data_pilha  = '0;
    model_reset();

    vecs[0] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 16'h0011, 16'h0011, 16'h0000, 1};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 16'h0022, 16'h0022, 16'h0011, 2};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 16'h0033, 16'h0033, 16'h0022, 3};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 16'h0055, 16'h0055, 16'h0011, 2};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0011, 16'h0000, 1};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 0};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 16'h0077, 16'h0000, 16'h0000, 0};

    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("reset/topo",     32'(b16.topo), 32'd0);
    chk("reset/segundo",  32'(b16.segundo), 32'd0);
    chk("reset/contagem", 32'(b16.contagem), 32'd0);
    chk("reset/vazio",    32'(b16.vazio), 32'd1);
    chk("reset/cheio",    32'(b16.cheio), 32'd0);
    chk("reset/erro",     32'(b16.erro), 32'd0);

    for (int i = 0; i < 8; i++) begin
      step(vecs[i].wren, vecs[i].ctl, vecs[i].wb, vecs[i].d, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d/topo_k", i),     32'(b16.topo),     32'(vecs[i].et));
      chk($sformatf("vec%0d/segundo_k", i),  32'(b16.segundo),  32'(vecs[i].es));
      chk($sformatf("vec%0d/contagem_k", i), 32'(b16.contagem), 32'(vecs[i].ec));
    end

    // Fill DEPTH=4 exactly, then drain: exercises array wrap and segundo refill.
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b1, 1'b0, 16'(i), "fill4");
    chk("fill4/topo", 32'(b4.topo), 32'd4);
    chk("fill4/cheio", 32'(b4.cheio), 32'd1);
    exp_q = '{16'd3, 16'd2, 16'd1, 16'd0};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b0, 16'h0, "drain4");
      e = exp_q.pop_front();
      chk($sformatf("drain4_%0d/topo", i), 32'(b4.topo), 32'(e));
    end
    chk("drain4/vazio", 32'(b4.vazio), 32'd1);

    // Push one past full on DEPTH=4.
    for (int i = 1; i <= 5; i++) step(1'b1, 1'b1, 1'b0, 16'(i), "over4");
    chk("over4/contagem", 32'(b4.contagem), 32'd4);
`ifdef PILHA_GUARD_EN
    chk("over4/topo", 32'(b4.topo), 32'd4);
    chk("over4/erro", 32'(b4.erro), 32'd1);
    exp_q = '{16'd3, 16'd2, 16'd1, 16'd0, 16'd0};
`else
    chk("over4/topo", 32'(b4.topo), 32'd5);
    chk("over4/erro", 32'(b4.erro), 32'd0);
    exp_q = '{16'd4, 16'd3, 16'd2, 16'd0, 16'd0};
`endif
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b0, 16'h0, "over4_pop");
      e = exp_q.pop_front();
      chk($sformatf("over4_pop%0d/topo", i), 32'(b4.topo), 32'(e));
    end
    chk("over4_pop/contagem", 32'(b4.contagem), 32'd0);

    // Asynchronous reset between edges in the middle of a push burst.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 16'($urandom_range(1, 16'hFFFF)), "burst");
    #2 reset = 1'b0;
    #1;
    chk("areset/topo16",     32'(b16.topo), 32'd0);
    chk("areset/segundo16",  32'(b16.segundo), 32'd0);
    chk("areset/contagem16", 32'(b16.contagem), 32'd0);
    chk("areset/vazio16",    32'(b16.vazio), 32'd1);
    chk("areset/topo4",      32'(b4.topo), 32'd0);
    chk("areset/erro4",      32'(b4.erro), 32'd0);
    b16.pilha_wren = 1'b0;
    b4.pilha_wren  = 1'b0;
    model_reset();
    #1 reset = 1'b1;
    @(negedge clock);
    step(1'b1, 1'b1, 1'b0, 16'h00AA, "post_reset");
    chk("post_reset/topo",     32'(b16.topo), 32'h00AA);
    chk("post_reset/contagem", 32'(b16.contagem), 32'd1);
    chk("post_reset/topo4",    32'(b4.topo), 32'h00AA);

    // Random traffic: a push-heavy phase followed by a pop-heavy phase.
    for (int ph = 0; ph < 2; ph++) begin
      for (int n = 0; n < 300; n++) begin
        r = $urandom_range(0, 9);
        if (r == 0)
          step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 16'($urandom), "rnd_idle");
        else if (r <= 2)
          step(1'b1, 1'($urandom_range(0, 1)), 1'b1, 16'($urandom), "rnd_wb");
        else if (r <= ((ph == 0) ? 8 : 4))
          step(1'b1, 1'b1, 1'b0, 16'($urandom), "rnd_push");
        else
          step(1'b1, 1'b0, 1'b0, 16'($urandom), "rnd_pop");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pilha_dados.md
# pilha_dados

Hardware data stack for the stack processor. It sits directly downstream of the control unit (UC) and executes the push, pop and ALU write-back commands that UC issues on `pilha_wren` / `controle_pilha` / `data_pilha`. The top two entries are held in registers, so both ALU operands are available without a read cycle. Deeper entries live in a circular register array.

## Interface
Parameters:
- `WIDTH`, default 16: data word width.
- `DEPTH`, default 16, minimum 3: total entries, including the two cached registers.
- `CW`, localparam, `$clog2(DEPTH+1)`: width of the occupancy count.

Ports:
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low.
- `pilha_wren`  in  1  command strobe; at most one command per cycle.
- `controle_pilha`  in  1  1 = push, 0 = pop; ignored when `ula_wb`=1.
- `ula_wb`  in  1  binary ALU write-back: pop two entries, push `data_pilha`.
- `data_pilha`  in  WIDTH  push / write-back data.
- `topo`  out  WIDTH  top of stack, registered.
- `segundo`  out  WIDTH  second entry, registered.
- `contagem`  out  CW  number of valid entries, 0..DEPTH.
- `vazio`  out  1  `contagem`==0.
- `cheio`  out  1  `contagem`==DEPTH.
- `erro`  out  1  sticky illegal-command flag (see Configuration).

## Operation
Internal storage:
- `topo`, `segundo` registers.
- Array `mem[DEPTH-2]` with a base pointer `base` (oldest entry) and the count.

Commands, all sampled at the rising edge when `pilha_wren`=1:
- PUSH (`controle_pilha`=1, `ula_wb`=0):
  - `mem[(base+contagem-2) mod (DEPTH-2)]`<=`segundo`, but only if `contagem`>=2.
  - `segundo`<=`topo`; `topo`<=`data_pilha`; `contagem`+1.
- POP (`controle_pilha`=0, `ula_wb`=0):
  - `topo`<=`segundo`.
  - `segundo`<=newest array entry if `contagem`>=3, else 0.
  - `contagem`-1.
- WB (`ula_wb`=1):
  - `topo`<=`data_pilha`.
  - `segundo`<=newest array entry if `contagem`>=3, else 0.
  - `contagem`-1.
- Priority: `ula_wb` over `controle_pilha`. With `pilha_wren`=0 all state holds.

Rules:
- Vacated slots read as 0. `topo`=0 whenever `contagem`=0; `segundo`=0 whenever `contagem`<2.
- Illegal commands:
  - PUSH when `cheio`.
  - POP when `vazio`.
  - WB when `contagem`<2.
  - Handling depends on `PILHA_GUARD_EN`.
- No arithmetic on data; only pointer arithmetic, modulo DEPTH-2.

## Timing
- Every command completes in 1 cycle. New `topo` / `segundo` / `contagem` are visible immediately after the capturing edge.
- Back-to-back commands are accepted every cycle; there is no busy or stall.
- `vazio` and `cheio` are decoded from the registered count: glitch-free and same-cycle consistent with `contagem`.
- Reset (`reset`=0), asynchronous and effective mid-burst:
  - `topo`=0, `segundo`=0, `contagem`=0, `base`=0.
  - `vazio`=1, `cheio`=0, `erro`=0.
  - Array contents are don't-care.
  - A command on the first edge after reset release executes normally.

## Configuration
`PILHA_GUARD_EN`:
- Defined:
  - An illegal command is ignored entirely; no state changes.
  - `erro` is set on the same edge and held until reset.
- Undefined: `erro` is tied 0, and illegal commands saturate:
  - PUSH on full: the oldest entry is discarded (`base`+1 mod DEPTH-2), then the normal push proceeds; `contagem` stays DEPTH.
  - POP on empty: no change.
  - WB with `contagem`=1: `topo`<=`data_pilha`, `contagem` stays 1.
  - WB with `contagem`=0: `topo`<=`data_pilha`, `contagem`=1.

## Test plan
- Reset then idle:
  - Response: `topo`=0, `segundo`=0, `contagem`=0, `vazio`=1, `cheio`=0, `erro`=0.
- PUSH 0x0011, 0x0022, 0x0033 on consecutive cycles:
  - Response: `topo`=0x0033, `segundo`=0x0022, `contagem`=3.
  - Then WB 0x0055: `topo`=0x0055, `segundo`=0x0011, `contagem`=2.
- DEPTH=4: PUSH 1,2,3,4, then POP ×4:
  - Response: `topo` 4,3,2,1 then 0; `vazio`=1 after the last pop.
  - Also checks array wrap and refill of `segundo`.
- DEPTH=4, guard on: PUSH 1..5:
  - Response: `contagem`=4, `topo`=4, `erro`=1.
  - Then POP on empty after draining: no change, `erro` stays 1.
- DEPTH=4, guard off: PUSH 1..5, then POP ×4:
  - Response: `topo` sequence 5,4,3,2; value 1 is lost; `erro`=0.
- Async reset pulse mid-way through a push burst, between clock edges:
  - Response: outputs clear immediately.
  - The next PUSH 0x00AA gives `topo`=0x00AA, `contagem`=1.
